// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for one tiled matmul pass chain on the core.
// Optional drain timeout with err flag: define CORE_SEQ_DRAIN_TIMEOUT_EN.
module core_seq_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int pass_bw = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic [addr_bw-1:0] n_act,
    input  logic [pass_bw-1:0] n_pass,
    input  logic               ofifo_valid,
    output logic [35:0]        inst,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [3:0] {
        S_IDLE, S_W_RD, S_W_LD, S_W_SETTLE, S_A_RD,
        S_EXEC, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    localparam logic [addr_bw:0]   ROW_C = (addr_bw+1)'(row);
    localparam logic [addr_bw:0]   COL_C = (addr_bw+1)'(col);
    localparam logic [addr_bw:0]   ONE_C = (addr_bw+1)'(1);
    localparam logic [addr_bw-1:0] ROW_A = addr_bw'(row);
    localparam logic [addr_bw-1:0] ONE_A = addr_bw'(1);
    localparam logic [pass_bw-1:0] ONE_K = pass_bw'(1);

    state_t             state, state_n;
    logic [addr_bw:0]   cnt, cnt_n;
    logic [addr_bw-1:0] d, d_n, d_inc;
    logic               pend, pend_n;
    logic [pass_bw-1:0] k, k_inc;
    logic [addr_bw-1:0] wp, ab, pb, na;
    logic [pass_bw-1:0] np;
    logic [addr_bw:0]   na_x, issued;
    logic               rd;
    logic               cen_p, wen_p, cen_s, wen_s;
    logic [addr_bw-1:0] a_p, a_s;
    logic               acc, l0_rd, l0_wr, exe, ld;
`ifdef CORE_SEQ_DRAIN_TIMEOUT_EN
    logic [9:0]         tmo;
    logic               err_q;
`endif

    assign na_x   = {1'b0, na};
    assign issued = {1'b0, d} + {{addr_bw{1'b0}}, pend};
    assign d_inc  = d + ONE_A;
    assign k_inc  = k + ONE_K;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign inst   = {2'b00, acc, cen_p, wen_p, a_p, cen_s, wen_s, a_s,
                     rd, 2'b00, l0_rd, l0_wr, exe, ld};

    always_comb begin
        state_n = state;
        cnt_n   = cnt + ONE_C;
        d_n     = d;
        pend_n  = 1'b0;
        rd      = 1'b0;
        cen_p   = 1'b1;
        wen_p   = 1'b1;
        a_p     = '0;
        cen_s   = 1'b1;
        wen_s   = 1'b1;
        a_s     = '0;
        acc     = 1'b0;
        l0_rd   = 1'b0;
        l0_wr   = 1'b0;
        exe     = 1'b0;
        ld      = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                d_n   = '0;
                if (start)
                    state_n = (n_act == '0 || n_pass == '0) ? S_DONE : S_W_RD;
            end
            S_W_RD: begin
                // l0_wr trails the read by one cycle to cover SRAM latency
                if (cnt < ROW_C) begin
                    cen_s = 1'b0;
                    a_s   = wp + cnt[addr_bw-1:0];
                end
                l0_wr = (cnt != '0);
                if (cnt == ROW_C) begin
                    state_n = S_W_LD;
                    cnt_n   = '0;
                end
            end
            S_W_LD: begin
                l0_rd = 1'b1;
                ld    = 1'b1;
                if (cnt == ROW_C - ONE_C) begin
                    state_n = S_W_SETTLE;
                    cnt_n   = '0;
                end
            end
            S_W_SETTLE: begin
                if (cnt == COL_C - ONE_C) begin
                    state_n = S_A_RD;
                    cnt_n   = '0;
                end
            end
            S_A_RD: begin
                if (cnt < na_x) begin
                    cen_s = 1'b0;
                    a_s   = ab + cnt[addr_bw-1:0];
                end
                l0_wr = (cnt != '0);
                if (cnt == na_x) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end
            end
            S_EXEC: begin
                l0_rd = 1'b1;
                exe   = 1'b1;
                if (cnt == na_x - ONE_C) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end
            end
            S_DRAIN: begin
                cnt_n = '0;
                acc   = (k != '0);
                a_p   = pb + d;
                // accumulate passes need a free pmem slot for the read
                rd = ofifo_valid && (issued < na_x) && (k == '0 || !pend);
                if (pend) begin
                    cen_p = 1'b0;
                    wen_p = 1'b0;
                end else if (rd && k != '0) begin
                    cen_p = 1'b0;
                end
                pend_n = rd;
                if (pend) begin
                    d_n = d_inc;
                    if (d_inc == na) begin
                        state_n = S_NEXT;
                        d_n     = '0;
                        pend_n  = 1'b0;
                    end
                end
`ifdef CORE_SEQ_DRAIN_TIMEOUT_EN
                if (tmo == 10'd1022 && !rd)
                    state_n = S_DONE;
`endif
            end
            S_NEXT: begin
                cnt_n   = '0;
                state_n = (k_inc == np) ? S_DONE : S_W_RD;
            end
            S_DONE: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            d     <= '0;
            pend  <= 1'b0;
            k     <= '0;
            wp    <= '0;
            ab    <= '0;
            pb    <= '0;
            na    <= '0;
            np    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            d     <= d_n;
            pend  <= pend_n;
            if (state == S_IDLE && start) begin
                wp <= w_base;
                ab <= a_base;
                pb <= p_base;
                na <= n_act;
                np <= n_pass;
                k  <= '0;
            end
            if (state == S_NEXT) begin
                k  <= k_inc;
                wp <= wp + ROW_A;
            end
        end
    end

`ifdef CORE_SEQ_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state != S_DRAIN || rd)
                tmo <= '0;
            else
                tmo <= tmo + 10'd1;
            if (state == S_IDLE && start)
                err_q <= 1'b0;
            else if (state == S_DRAIN && state_n == S_DONE)
                err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: traces inst per cycle and checks
// read/write address streams, phase lengths and done timing.
module tb_core_seq_ctrl;
    localparam logic [35:0] INST_IDLE = 36'h1800C0000;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [10:0] w_base, a_base, p_base, n_act;
    logic [3:0]  n_pass;
    logic [35:0] inst;
    logic        busy, done, err;

    core_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .a_base(a_base), .p_base(p_base),
        .n_act(n_act), .n_pass(n_pass), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-cycle trace entry: {err, done, busy, inst}
    logic [38:0] tr[$];
    int rd_addr[$];
    int pm_acc[$];
    int pm_cyc[$];
    int n_l0wr, n_load, n_exec, n_acc, n_ord, n_done, lag_bad, ord_pair;
    int done_at;

    task automatic kick(input logic [10:0] wb, ab, pb, na,
                        input logic [3:0] np);
        @(negedge clk);
        w_base = wb; a_base = ab; p_base = pb; n_act = na; n_pass = np;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input logic [10:0] wb, ab, pb, na,
                       input logic [3:0] np, input int budget,
                       input bit expect_done);
        kick(wb, ab, pb, na, np);
        tr.delete();
        done_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            tr.push_back({err, done, busy, inst});
            if (done) begin
                done_at = i;
                break;
            end
        end
        if (expect_done) begin
            check("done_seen", done_at >= 0, 1);
            @(negedge clk);
            check("post_busy", busy, 0);
            check("post_done", done, 0);
            check("post_inst", inst, INST_IDLE);
        end
    endtask

    task automatic analyze();
        rd_addr.delete(); pm_acc.delete(); pm_cyc.delete();
        n_l0wr = 0; n_load = 0; n_exec = 0; n_acc = 0;
        n_ord = 0; n_done = 0; lag_bad = 0; ord_pair = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (!tr[i][19]) begin
                rd_addr.push_back(int'(tr[i][17:7]));
                if (i + 1 >= tr.size() || !tr[i+1][2]) lag_bad++;
            end
            if (!tr[i][32]) begin
                pm_acc.push_back(int'({tr[i][31], tr[i][30:20]}));
                pm_cyc.push_back(i);
            end
            if (tr[i][2]) n_l0wr++;
            if (tr[i][0]) n_load++;
            if (tr[i][1]) n_exec++;
            if (tr[i][33]) n_acc++;
            if (tr[i][6]) n_ord++;
            if (tr[i][37]) n_done++;
            if (i > 0 && tr[i][6] && tr[i-1][6] && tr[i][33]) ord_pair++;
        end
    endtask

    task automatic check_list(input string tag, input int got[$],
                              input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    int exp_rd[$];
    int exp_pm[$];
    bit seen;

    initial begin
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
        w_base = '0; a_base = '0; p_base = '0; n_act = '0; n_pass = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_inst", inst, INST_IDLE);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // single pass, n_act=4
        run(11'd0, 11'd16, 11'd0, 11'd4, 4'd1, 200, 1);
        analyze();
        exp_rd = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 17, 18, 19};
        check_list("p1_rd", rd_addr, exp_rd);
        check("p1_lag", lag_bad, 0);
        check("p1_l0wr", n_l0wr, 12);
        check("p1_load", n_load, 8);
        check("p1_exec", n_exec, 4);
        check("p1_ord", n_ord, 4);
        check("p1_acc", n_acc, 0);
        exp_pm = '{0, 1, 2, 3};
        check_list("p1_pm", pm_acc, exp_pm);
        check("p1_pm_cyc0", pm_cyc.size() > 0 ? pm_cyc[0] : -1, 35);
        check("p1_pm_span", pm_cyc.size() == 4 ? pm_cyc[3] - pm_cyc[0] : -1, 3);
        check("p1_done_at", done_at, 40);
        check("p1_ndone", n_done, 1);

        // two passes, second accumulates
        run(11'd32, 11'd16, 11'd0, 11'd4, 4'd2, 300, 1);
        analyze();
        exp_rd = '{32, 33, 34, 35, 36, 37, 38, 39, 16, 17, 18, 19,
                   40, 41, 42, 43, 44, 45, 46, 47, 16, 17, 18, 19};
        check_list("p2_rd", rd_addr, exp_rd);
        check("p2_lag", lag_bad, 0);
        check("p2_l0wr", n_l0wr, 24);
        check("p2_load", n_load, 16);
        check("p2_exec", n_exec, 8);
        check("p2_ord", n_ord, 8);
        check("p2_acc", n_acc, 8);
        check("p2_ord_pair", ord_pair, 0);
        exp_pm = '{0, 1, 2, 3, 2048, 0, 2049, 1, 2050, 2, 2051, 3};
        check_list("p2_pm", pm_acc, exp_pm);
        check("p2_pm_cyc4", pm_cyc.size() > 4 ? pm_cyc[4] : -1, 74);
        check("p2_pm_span", pm_cyc.size() == 12 ? pm_cyc[11] - pm_cyc[4] : -1, 7);
        check("p2_done_at", done_at, 83);
        check("p2_ndone", n_done, 1);

        // zero-size configurations go straight to DONE
        run(11'd0, 11'd16, 11'd0, 11'd0, 4'd1, 20, 1);
        analyze();
        check("z_act_done_at", done_at, 0);
        check("z_act_srd", rd_addr.size(), 0);
        check("z_act_pm", pm_acc.size(), 0);
        run(11'd0, 11'd16, 11'd0, 11'd4, 4'd0, 20, 1);
        analyze();
        check("z_pass_done_at", done_at, 0);
        check("z_pass_srd", rd_addr.size(), 0);

        // reset during EXEC aborts, then a clean rerun
        kick(11'd0, 11'd16, 11'd0, 11'd4, 4'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = inst[1];
        end
        check("exec_reached", seen, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_inst", inst, INST_IDLE);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", inst, INST_IDLE);
        run(11'd0, 11'd16, 11'd0, 11'd4, 4'd1, 200, 1);
        analyze();
        check("rerun_done_at", done_at, 40);
        exp_pm = '{0, 1, 2, 3};
        check_list("rerun_pm", pm_acc, exp_pm);

        // OFIFO never delivers in DRAIN
        ofifo_valid = 1'b0;
`ifdef CORE_SEQ_DRAIN_TIMEOUT_EN
        run(11'd0, 11'd16, 11'd0, 11'd2, 4'd1, 1200, 1);
        check("tmo_done_at", done_at, 1053);
        check("tmo_err_done", done_at >= 0 ? tr[done_at][38] : 1'b0, 1);
        check("tmo_err_hold", err, 1);
        ofifo_valid = 1'b1;
        run(11'd0, 11'd16, 11'd0, 11'd0, 4'd1, 20, 1);
        check("tmo_err_clr", err, 0);
`else
        run(11'd0, 11'd16, 11'd0, 11'd2, 4'd1, 1100, 0);
        analyze();
        check("wait_busy", busy, 1);
        check("wait_ndone", n_done, 0);
        check("wait_err", err, 0);
        ofifo_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("wait_rst_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
